mpu_sample_cal: RTL and testbench
=================================

# mpu_sample_cal

Downstream consumer of the MPU I2C reader's `mpu_data_pack`. It latches each 14-byte burst on `mpu_read_done` and splits it into seven signed 16-bit words: accel XYZ, temperature, and gyro XYZ. On request it averages a power-of-two number of gyro samples into a per-axis bias, then subtracts that bias from every later gyro sample. It feeds the attitude/fusion stage with a one-cycle `imu_valid` strobe.

## Interface
- `CAL_LOG2`, default 6: log2 of the calibration sample count (64 samples); legal range 0..10.
- `clk`  in  1  system clock (50 MHz)
- `rst_n`  in  1  synchronous, active-low reset
- `mpu_read_done`  in  1  one-cycle pulse; `mpu_data_pack` is valid in that cycle
- `mpu_data_pack`  in  112  burst read starting at register 0x3B; byte 0 is in [111:104]
- `cal_start`  in  1  one-cycle pulse; starts or restarts gyro bias calibration
- `acc_x`, `acc_y`, `acc_z`  out  16  signed accel, raw
- `temp_raw`  out  16  signed temperature, raw
- `gyro_x`, `gyro_y`, `gyro_z`  out  16  signed gyro, bias-corrected
- `imu_valid`  out  1  one-cycle pulse; all seven outputs are updated in this cycle
- `cal_busy`  out  1  high while calibration is accumulating
- `cal_done`  out  1  one-cycle pulse when the bias is latched

## Operation
- Word k (k = 0..6) is `mpu_data_pack[111-16k -: 16]`, big-endian (high byte first). Word order: ax, ay, az, temp, gx, gy, gz.
- States:
  - RAW: the state after reset; bias = 0.
  - CAL: accumulating gyro samples.
  - RUN: bias is applied.
- `cal_start` in any state: go to CAL, clear the three accumulators and the sample counter, and hold the current bias at 0.
- In CAL:
  - Each stage-1 sample adds its sign-extended gx/gy/gz to accumulators of width 16+CAL_LOG2 and increments the counter.
  - `imu_valid` is suppressed.
- When the counter reaches 2^CAL_LOG2:
  - Next cycle, bias_axis = accumulator >>> CAL_LOG2 (arithmetic shift, floor rounding), truncated to 16 bits.
  - `cal_done` pulses for one cycle and the state goes to RUN.
- In RAW and RUN:
  - Each sample produces `imu_valid`.
  - gyro_out = gyro − bias, computed in 17 bits and then reduced to 16 bits (see Configuration).
- Accel and temperature values pass through unmodified.
- `cal_start` in the same cycle as `mpu_read_done`: `cal_start` wins, and that sample is neither accumulated nor output.
- Back-to-back `mpu_read_done` pulses on consecutive cycles are each processed; the pipeline is fully pipelined with throughput 1 sample per cycle.
- A `cal_start` received during CAL restarts the count from 0.

## Timing
- Stage 1, cycle n+1: the pack is registered and split into words.
- Stage 2, cycle n+2: bias is subtracted, outputs are registered, and `imu_valid` is high.
- Latency from `mpu_read_done` to `imu_valid` is exactly 2 cycles.
- Outputs hold their value between strobes.
- When the final calibration sample arrives at `mpu_read_done` cycle n, `cal_done` is high at cycle n+2.
- The first corrected sample needs a `mpu_read_done` at cycle n+2 or later.
- Reset values:
  - All data outputs 0.
  - `imu_valid`, `cal_busy`, `cal_done` all 0.
  - Bias 0, accumulators 0, state RAW.
- Reset asserted mid-calibration: calibration is abandoned, state is RAW, bias is 0, and any in-flight pipeline samples are discarded.

## Configuration
- `MPU_GYRO_SAT_EN`:
  - Defined: the corrected gyro saturates to [−32768, 32767].
  - Undefined: the result is the low 16 bits of the difference (two's-complement wrap).
- Accel and temperature paths are unaffected in both cases.

## Structure
- Package `mpu_pkg` holds:
  - state encoding: ST_RAW, ST_CAL, ST_RUN
  - word index constants: W_AX..W_GZ = 0..6
  - `MPU_PACK_W` = 112
  - `MPU_WORD_W` = 16
- One sub-module, `mpu_gyro_bias`: holds the three accumulators, the sample counter, the bias registers, and `cal_done` generation. It is instantiated once and serves all three axes.
- The top level contains the unpack stage, the subtract/saturate stage, and the FSM.

## Test plan
- Unpack: pack holds bytes 0x01..0x0E, pulse `mpu_read_done`.
  - Expected at +2 cycles: acc_x=0x0102, acc_y=0x0304, acc_z=0x0506, temp=0x0708, gx=0x090A, gy=0x0B0C, gz=0x0D0E, `imu_valid` high for exactly 1 cycle.
- Calibration, CAL_LOG2=2: `cal_start`, then four samples with gx = 10, 12, 14, 16 and gy = −3 each.
  - Expected: `cal_done` 2 cycles after the 4th pulse, no `imu_valid` during CAL.
  - Next sample gx=100, gy=0 gives gyro_x=87, gyro_y=3.
- Floor rounding: calibration samples gz = −1, −1, −1, −2 (sum −5).
  - Expected bias −2; then gz=0 gives gyro_z=2.
- Saturation: bias gx=−100, then input gx=0x7FF0.
  - With `MPU_GYRO_SAT_EN`: gyro_x=0x7FFF.
  - Without it: gyro_x=0x8054.
- Collision and restart:
  - `cal_start` coincident with `mpu_read_done`: that sample is dropped and the count starts at 0.
  - `cal_start` after 2 of 4 samples: 4 further samples are required before `cal_done`.
- Reset mid-CAL: `rst_n` low for 1 cycle after 3 samples.
  - Expected: all outputs 0 and `cal_busy` 0.
  - The next sample passes through raw with bias 0 and `imu_valid` at +2 cycles.

Source files
------------

// File: rtl/mpu_pkg.sv
// -----------------------------------------------------------------------------
// mpu_pkg
// Shared definitions for the MPU sample calibration block:
//   - calibration state encoding (ST_RAW / ST_CAL / ST_RUN)
//   - word indices inside the 14-byte burst (W_AX .. W_GZ)
//   - pack and word widths
//   - get_word(): extracts big-endian word k from the burst
// -----------------------------------------------------------------------------
package mpu_pkg;

  localparam int MPU_PACK_W    = 112;
  localparam int MPU_WORD_W    = 16;
  localparam int MPU_NUM_WORDS = MPU_PACK_W / MPU_WORD_W;

  // Word order as read from register 0x3B onward.
  localparam int W_AX = 0;
  localparam int W_AY = 1;
  localparam int W_AZ = 2;
  localparam int W_T  = 3;
  localparam int W_GX = 4;
  localparam int W_GY = 5;
  localparam int W_GZ = 6;

  typedef enum logic [1:0] {
    ST_RAW = 2'd0,
    ST_CAL = 2'd1,
    ST_RUN = 2'd2
  } cal_state_e;

  typedef logic signed [MPU_WORD_W-1:0] word_t;

  // Byte 0 of the burst sits in the top byte of the pack, so word k starts
  // 16*k bits below the MSB.
  function automatic word_t get_word(input logic [MPU_PACK_W-1:0] pack, input int k);
    return pack[MPU_PACK_W-1-MPU_WORD_W*k -: MPU_WORD_W];
  endfunction

endpackage

// File: rtl/mpu_gyro_bias.sv
// -----------------------------------------------------------------------------
// mpu_gyro_bias
// Averages 2^CAL_LOG2 gyro samples per axis into a signed 16-bit bias.
//   clk, rst_n        : clock, synchronous active-low reset
//   i_clear           : restart calibration (clears accumulators, counter, bias)
//   i_acc_en          : one calibration sample is present on i_gx/i_gy/i_gz
//   i_gx, i_gy, i_gz  : signed gyro sample
//   o_bias_x/y/z      : latched bias (0 until a calibration completes)
//   o_cal_last        : combinational, the sample being accumulated is the last
//   o_cal_done        : one-cycle pulse in the cycle the new bias is visible
// -----------------------------------------------------------------------------
module mpu_gyro_bias
  import mpu_pkg::*;
#(
  parameter int CAL_LOG2 = 6
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_clear,
  input  logic  i_acc_en,
  input  word_t i_gx,
  input  word_t i_gy,
  input  word_t i_gz,
  output word_t o_bias_x,
  output word_t o_bias_y,
  output word_t o_bias_z,
  output logic  o_cal_last,
  output logic  o_cal_done
);

  // Sum of 2^CAL_LOG2 16-bit samples always fits in 16+CAL_LOG2 signed bits.
  localparam int ACC_W = MPU_WORD_W + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CAL_LOG2) - 1);

  logic signed [ACC_W-1:0] r_acc [3];
  logic signed [ACC_W-1:0] w_sum [3];
  word_t                   w_in  [3];
  word_t                   r_bias[3];
  logic        [CNT_W-1:0] r_cnt;
  logic                    r_cal_done;
  logic                    w_last;

  assign w_in[0] = i_gx;
  assign w_in[1] = i_gy;
  assign w_in[2] = i_gz;

  // Sign-extending cast of the signed sample into the accumulator width.
  for (genvar a = 0; a < 3; a++) begin : g_sum
    assign w_sum[a] = r_acc[a] + ACC_W'(w_in[a]);
  end

  // The bias is taken from the running sum including the final sample, so
  // it is ready in the same cycle the counter would reach 2^CAL_LOG2.
  assign w_last = i_acc_en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cal_done <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        r_acc[a]  <= '0;
        r_bias[a] <= '0;
      end
    end else begin
      r_cal_done <= 1'b0;
      if (i_clear) begin
        r_cnt <= '0;
        for (int a = 0; a < 3; a++) begin
          r_acc[a]  <= '0;
          r_bias[a] <= '0;
        end
      end else if (i_acc_en) begin
        r_cnt <= r_cnt + 1'b1;
        for (int a = 0; a < 3; a++) begin
          r_acc[a] <= w_sum[a];
        end
        if (w_last) begin
          r_cal_done <= 1'b1;
          // Arithmetic shift gives floor rounding for negative sums.
          for (int a = 0; a < 3; a++) begin
            r_bias[a] <= word_t'(w_sum[a] >>> CAL_LOG2);
          end
        end
      end
    end
  end

  assign o_bias_x   = r_bias[0];
  assign o_bias_y   = r_bias[1];
  assign o_bias_z   = r_bias[2];
  assign o_cal_last = w_last;
  assign o_cal_done = r_cal_done;

endmodule

// File: rtl/mpu_sample_cal.sv
// -----------------------------------------------------------------------------
// mpu_sample_cal
// Splits each 14-byte MPU burst into seven signed words, calibrates a gyro
// bias on request and removes it from later gyro samples.
//   clk, rst_n            : 50 MHz clock, synchronous active-low reset
//   mpu_read_done         : one-cycle pulse, mpu_data_pack valid
//   mpu_data_pack         : burst from register 0x3B, byte 0 in [111:104]
//   cal_start             : one-cycle pulse, (re)starts bias calibration
//   acc_x/y/z, temp_raw   : raw signed accel / temperature
//   gyro_x/y/z            : bias-corrected signed gyro
//   imu_valid             : one-cycle strobe, all seven outputs updated
//   cal_busy              : high while accumulating calibration samples
//   cal_done              : one-cycle pulse when the bias is latched
// Pipeline: stage 1 registers and splits the pack, stage 2 subtracts the bias
// and registers the outputs (2 cycles from mpu_read_done to imu_valid).
// Build option MPU_GYRO_SAT_EN: saturate the corrected gyro instead of
// wrapping it.
// -----------------------------------------------------------------------------
module mpu_sample_cal
  import mpu_pkg::*;
#(
  parameter int CAL_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mpu_read_done,
  input  logic [MPU_PACK_W-1:0] mpu_data_pack,
  input  logic                  cal_start,
  output word_t                 acc_x,
  output word_t                 acc_y,
  output word_t                 acc_z,
  output word_t                 temp_raw,
  output word_t                 gyro_x,
  output word_t                 gyro_y,
  output word_t                 gyro_z,
  output logic                  imu_valid,
  output logic                  cal_busy,
  output logic                  cal_done
);

  // gyro - bias in 17 bits, then reduced to 16 bits.
  function automatic word_t gyro_correct(input word_t g, input word_t b);
`ifdef MPU_GYRO_SAT_EN
    logic signed [MPU_WORD_W:0] d;
    d = {g[MPU_WORD_W-1], g} - {b[MPU_WORD_W-1], b};
    // Top two bits disagree only when the result left the 16-bit range.
    if (d[MPU_WORD_W] != d[MPU_WORD_W-1]) begin
      return d[MPU_WORD_W] ? 16'h8000 : 16'h7FFF;
    end
    return d[MPU_WORD_W-1:0];
`else
    // The low 16 bits of the 17-bit difference equal the 16-bit wrap.
    return g - b;
`endif
  endfunction

  cal_state_e r_state;
  logic       r_cal_busy;

  logic       r_s1_valid;
  word_t      r_s1_word [MPU_NUM_WORDS];

  logic       r_imu_valid;
  word_t      r_acc_x, r_acc_y, r_acc_z, r_temp;
  word_t      r_gyro_x, r_gyro_y, r_gyro_z;

  word_t      w_bias_x, w_bias_y, w_bias_z;
  logic       w_cal_last;
  logic       w_acc_en;
  logic       w_out_en;

  // ---------------------------------------------------------------------------
  // Stage 1: register and split. A sample arriving with cal_start is dropped.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= only, so every always_ff reads
  // the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= mpu_read_done && !cal_start;
    end
  end

  // NOTE: the word registers carry no reset; r_s1_valid alone decides whether
  // they are consumed, so reset only needs to clear the valid bit.
  always_ff @(posedge clk) begin
    if (mpu_read_done) begin
      for (int k = 0; k < MPU_NUM_WORDS; k++) begin
        r_s1_word[k] <= get_word(mpu_data_pack, k);
      end
    end
  end

  // A stage-1 sample either feeds calibration or goes to the outputs.
  assign w_acc_en = r_s1_valid && (r_state == ST_CAL) && !cal_start;
  assign w_out_en = r_s1_valid && (r_state != ST_CAL);

  // ---------------------------------------------------------------------------
  // Bias calibration
  // ---------------------------------------------------------------------------
  mpu_gyro_bias #(
    .CAL_LOG2 (CAL_LOG2)
  ) u_gyro_bias (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (cal_start),
    .i_acc_en   (w_acc_en),
    .i_gx       (r_s1_word[W_GX]),
    .i_gy       (r_s1_word[W_GY]),
    .i_gz       (r_s1_word[W_GZ]),
    .o_bias_x   (w_bias_x),
    .o_bias_y   (w_bias_y),
    .o_bias_z   (w_bias_z),
    .o_cal_last (w_cal_last),
    .o_cal_done (cal_done)
  );

  // ---------------------------------------------------------------------------
  // FSM: RAW after reset, CAL while accumulating, RUN once a bias exists.
  // Leaving CAL on the last accumulated sample lines RUN up with cal_done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_RAW;
      r_cal_busy <= 1'b0;
    end else if (cal_start) begin
      r_state    <= ST_CAL;
      r_cal_busy <= 1'b1;
    end else if (r_state == ST_CAL && w_cal_last) begin
      r_state    <= ST_RUN;
      r_cal_busy <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: subtract bias, register outputs; outputs hold between strobes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_imu_valid <= 1'b0;
      r_acc_x     <= '0;
      r_acc_y     <= '0;
      r_acc_z     <= '0;
      r_temp      <= '0;
      r_gyro_x    <= '0;
      r_gyro_y    <= '0;
      r_gyro_z    <= '0;
    end else begin
      r_imu_valid <= w_out_en;
      if (w_out_en) begin
        r_acc_x  <= r_s1_word[W_AX];
        r_acc_y  <= r_s1_word[W_AY];
        r_acc_z  <= r_s1_word[W_AZ];
        r_temp   <= r_s1_word[W_T];
        r_gyro_x <= gyro_correct(r_s1_word[W_GX], w_bias_x);
        r_gyro_y <= gyro_correct(r_s1_word[W_GY], w_bias_y);
        r_gyro_z <= gyro_correct(r_s1_word[W_GZ], w_bias_z);
      end
    end
  end

  assign acc_x     = r_acc_x;
  assign acc_y     = r_acc_y;
  assign acc_z     = r_acc_z;
  assign temp_raw  = r_temp;
  assign gyro_x    = r_gyro_x;
  assign gyro_y    = r_gyro_y;
  assign gyro_z    = r_gyro_z;
  assign imu_valid = r_imu_valid;
  assign cal_busy  = r_cal_busy;

endmodule

// File: tb/tb_mpu_sample_cal.sv
// -----------------------------------------------------------------------------
// tb_mpu_sample_cal
// Directed bench for mpu_sample_cal with CAL_LOG2 = 2 (4 calibration samples).
// Expected output words and cal_done cycles are queued when stimulus is
// driven and compared by a monitor when the DUT strobes.
// -----------------------------------------------------------------------------
module tb_mpu_sample_cal;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mpu_read_done = 1'b0;
  logic [111:0]  mpu_data_pack = '0;
  logic          cal_start = 1'b0;
  logic [15:0]   acc_x, acc_y, acc_z, temp_raw, gyro_x, gyro_y, gyro_z;
  logic          imu_valid, cal_busy, cal_done;

  mpu_sample_cal #(.CAL_LOG2(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mpu_read_done (mpu_read_done),
    .mpu_data_pack (mpu_data_pack),
    .cal_start     (cal_start),
    .acc_x         (acc_x),
    .acc_y         (acc_y),
    .acc_z         (acc_z),
    .temp_raw      (temp_raw),
    .gyro_x        (gyro_x),
    .gyro_y        (gyro_y),
    .gyro_z        (gyro_z),
    .imu_valid     (imu_valid),
    .cal_busy      (cal_busy),
    .cal_done      (cal_done)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] ax, ay, az, t, gx, gy, gz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          done_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_ax = '0;
  logic [15:0] last_gx = '0;
  exp_t        mon_e;
  exp_t        none;
  int          mon_d;

`ifdef MPU_GYRO_SAT_EN
  localparam logic [15:0] SAT_EXP = 16'h7FFF;
`else
  localparam logic [15:0] SAT_EXP = 16'h8054;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [111:0] mkpack(input logic [15:0] ax, ay, az, t, gx, gy, gz);
    return {ax, ay, az, t, gx, gy, gz};
  endfunction

  function automatic exp_t mkexp(input logic [15:0] ax, ay, az, t, gx, gy, gz);
    exp_t e;
    e.ax = ax; e.ay = ay; e.az = az; e.t = t;
    e.gx = gx; e.gy = gy; e.gz = gz; e.due = 0;
    return e;
  endfunction

  // Drive one burst; the DUT's strobe is due one clock after the capture edge.
  task automatic send(input logic [111:0] pack, input bit cs, input bit out,
                      input bit last, input exp_t e);
    mpu_data_pack = pack;
    mpu_read_done = 1'b1;
    cal_start     = cs;
    @(posedge clk); #1;
    mpu_read_done = 1'b0;
    cal_start     = 1'b0;
    if (out) begin
      e.due = cyc + 1;
      sb.push_back(e);
    end
    if (last) done_q.push_back(cyc + 1);
  endtask

  task automatic cal_sample(input logic [15:0] gx, gy, gz, input bit last);
    send(mkpack(16'h1111, 16'h2222, 16'h3333, 16'h4444, gx, gy, gz), 1'b0, 1'b0, last, none);
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    @(posedge clk); #1;
    cal_start = 1'b0;
    check("cal_busy_after_start", cal_busy, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares strobed outputs against the scoreboard, checks hold
  // behaviour between strobes and the cal_done timing.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ax = '0;
      last_gx = '0;
    end else begin
      if (imu_valid) begin
        check("imu_valid_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("imu_valid_cycle", cyc, mon_e.due);
          check("acc_x", acc_x, mon_e.ax);
          check("acc_y", acc_y, mon_e.ay);
          check("acc_z", acc_z, mon_e.az);
          check("temp_raw", temp_raw, mon_e.t);
          check("gyro_x", gyro_x, mon_e.gx);
          check("gyro_y", gyro_y, mon_e.gy);
          check("gyro_z", gyro_z, mon_e.gz);
          last_ax = mon_e.ax;
          last_gx = mon_e.gx;
        end
      end else begin
        check("hold_acc_x", acc_x, last_ax);
        check("hold_gyro_x", gyro_x, last_gx);
      end
      if (cal_done) begin
        check("cal_done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          mon_d = done_q.pop_front();
          check("cal_done_cycle", cyc, mon_d);
        end
      end
    end
  end

  initial begin
    none = mkexp('0, '0, '0, '0, '0, '0, '0);

    // Reset state
    idle(3);
    rst_n = 1'b1;
    check("rst_acc_x", acc_x, 0);
    check("rst_acc_y", acc_y, 0);
    check("rst_acc_z", acc_z, 0);
    check("rst_temp", temp_raw, 0);
    check("rst_gyro_x", gyro_x, 0);
    check("rst_gyro_y", gyro_y, 0);
    check("rst_gyro_z", gyro_z, 0);
    check("rst_imu_valid", imu_valid, 0);
    check("rst_cal_busy", cal_busy, 0);
    check("rst_cal_done", cal_done, 0);
    idle(2);

    // Unpack bytes 0x01..0x0E in RAW state
    send(112'h0102030405060708090A0B0C0D0E, 1'b0, 1'b1, 1'b0,
         mkexp(16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C, 16'h0D0E));
    idle(3);

    // Back-to-back raw samples
    send(mkpack(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hA5A5, 16'h5A5A, 16'h0000), 1'b0, 1'b1, 1'b0,
         mkexp(16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hA5A5, 16'h5A5A, 16'h0000));
    send(mkpack(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'h8001), 1'b0, 1'b1, 1'b0,
         mkexp(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'h8001));
    idle(3);

    // Calibration: gx 10,12,14,16 -> bias 13; gy -3 -> bias -3
    start_cal();
    cal_sample(16'd10, 16'hFFFD, 16'd0, 1'b0);
    cal_sample(16'd12, 16'hFFFD, 16'd0, 1'b0);
    cal_sample(16'd14, 16'hFFFD, 16'd0, 1'b0);
    check("cal_busy_during_cal", cal_busy, 1);
    cal_sample(16'd16, 16'hFFFD, 16'd0, 1'b1);
    idle(2);
    check("cal_busy_after_done", cal_busy, 0);
    send(mkpack(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'd100, 16'd0, 16'd0), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'd87, 16'd3, 16'd0));
    idle(3);

    // Floor rounding: gz -1,-1,-1,-2 -> bias -2
    start_cal();
    cal_sample(16'd0, 16'd0, 16'hFFFF, 1'b0);
    cal_sample(16'd0, 16'd0, 16'hFFFF, 1'b0);
    cal_sample(16'd0, 16'd0, 16'hFFFF, 1'b0);
    cal_sample(16'd0, 16'd0, 16'hFFFE, 1'b1);
    idle(2);
    send(mkpack(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'd5, 16'd0, 16'd0), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'd5, 16'd0, 16'd2));
    idle(3);

    // Saturation / wrap: bias gx -100, input 0x7FF0
    start_cal();
    for (int i = 0; i < 4; i++) cal_sample(16'hFF9C, 16'd0, 16'd0, i == 3);
    idle(2);
    send(mkpack(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FF0, 16'h0010, 16'h0000), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0000, 16'h0000, 16'h0000, 16'h0000, SAT_EXP, 16'h0010, 16'h0000));
    idle(3);

    // Collision: cal_start with mpu_read_done drops that sample
    start_cal();
    send(mkpack(16'h0, 16'h0, 16'h0, 16'h0, 16'd1000, 16'd0, 16'd0), 1'b1, 1'b0, 1'b0, none);
    for (int i = 0; i < 4; i++) cal_sample(16'd4, 16'd0, 16'd0, i == 3);
    idle(2);
    send(mkpack(16'h0042, 16'h0, 16'h0, 16'h0, 16'd1000, 16'd0, 16'd0), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0042, 16'h0, 16'h0, 16'h0, 16'd996, 16'd0, 16'd0));
    idle(3);

    // Restart after 2 of 4 samples
    start_cal();
    cal_sample(16'd400, 16'd0, 16'd0, 1'b0);
    cal_sample(16'd400, 16'd0, 16'd0, 1'b0);
    start_cal();
    for (int i = 0; i < 4; i++) cal_sample(16'd8, 16'd0, 16'd0, i == 3);
    idle(2);
    send(mkpack(16'h0043, 16'h0, 16'h0, 16'h0, 16'd8, 16'd0, 16'd0), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0043, 16'h0, 16'h0, 16'h0, 16'd0, 16'd0, 16'd0));
    idle(3);

    // Reset mid-calibration after 3 samples
    start_cal();
    for (int i = 0; i < 3; i++) cal_sample(16'd50, 16'd0, 16'd0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_rst_acc_x", acc_x, 0);
    check("mid_rst_temp", temp_raw, 0);
    check("mid_rst_gyro_x", gyro_x, 0);
    check("mid_rst_gyro_y", gyro_y, 0);
    check("mid_rst_imu_valid", imu_valid, 0);
    check("mid_rst_cal_busy", cal_busy, 0);
    check("mid_rst_cal_done", cal_done, 0);
    send(mkpack(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h1234, 16'hFFF0, 16'h0050), 1'b0, 1'b1, 1'b0,
         mkexp(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h1234, 16'hFFF0, 16'h0050));
    idle(5);

    // Everything queued must have been observed
    check("pending_samples", sb.size(), 0);
    check("pending_cal_done", done_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
